// File: rtl/ttpu_pkg.sv
// Shared definitions for the unit read server: default bus widths and a
// one-hot helper.
package ttpu_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned MAX_UNITS  = 16;
    localparam int unsigned MAX_IDX_W  = 4;

    // One-hot of idx within an n-wide field; zero if idx is out of range.
    // Callers truncate the result to their own unit count.
    function automatic logic [MAX_UNITS-1:0] onehot(input int unsigned idx,
                                                    input int unsigned n);
        logic [MAX_UNITS-1:0] v;
        v = '0;
        if ((idx < n) && (idx < MAX_UNITS)) begin
            v[idx[MAX_IDX_W-1:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/unit_read_server_if.sv
// Unit-side request/response bundle of the read server. The master modport
// is the requesting side (pointer array / MAC units), slave is the server.
interface unit_read_server_if
    import ttpu_pkg::*;
#(
    parameter int unsigned N_UNITS = 4,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
);

    logic [N_UNITS-1:0]             active_units;
    logic [N_UNITS-1:0]             req_valid;
    logic [N_UNITS-1:0][ADDR_W-1:0] req_addr;
    logic [N_UNITS-1:0]             req_ready;
    logic [N_UNITS-1:0]             resp_valid;
    logic [N_UNITS-1:0][DATA_W-1:0] resp_data;

    modport master (
        output active_units,
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  active_units,
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping, and moves the pointer just past the winner when advanced.
module rr_arbiter
    import ttpu_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    input  logic            advance_i,
    output logic [N-1:0]    grant_onehot_o,
    output logic [IdxW-1:0] grant_idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW:0]   cand;
    logic            found;

    // Scan upward from the pointer, wrapping, and pick the first requester.
    always_comb begin
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IdxW + 1)'(k);
            if (cand >= (IdxW + 1)'(N)) begin
                cand = cand - (IdxW + 1)'(N);
            end
            if (!found && req_i[cand[IdxW-1:0]]) begin
                found       = 1'b1;
                grant_idx_o = cand[IdxW-1:0];
            end
        end
        grant_onehot_o = found ? N'(onehot(32'(grant_idx_o), N)) : '0;
    end

    // Next pointer: one past the winner, wrapping the last unit back to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (grant_idx_o == IdxW'(N - 1)) ? '0 : grant_idx_o + IdxW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/unit_read_server.sv
// Read-side responder: arbitrates per-unit read requests onto a single-port
// SRAM with 1-cycle read latency and routes each word back to its requester.
module unit_read_server
    import ttpu_pkg::*;
#(
    parameter int unsigned N_UNITS = 4,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    localparam int unsigned IdxW   = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    unit_read_server_if.slave   bus_io,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    logic [N_UNITS-1:0] elig;
    logic [N_UNITS-1:0] grant_oh;
    logic [IdxW-1:0]    grant_idx;
    logic               accept;

    logic                           s1_valid_q, s1_valid_d;
    logic [IdxW-1:0]                s1_id_q, s1_id_d;
    logic [N_UNITS-1:0]             resp_valid_q, resp_valid_d;
    logic [N_UNITS-1:0][DATA_W-1:0] resp_data_q, resp_data_d;

    // Reset gates eligibility so nothing is granted while rst_n is low.
    assign elig   = bus_io.req_valid & bus_io.active_units & {N_UNITS{rst_n}};
    // A grant is issued whenever anyone is eligible, and valid is already
    // part of eligibility, so every grant is an accept.
    assign accept = |elig;

    rr_arbiter #(
        .N (N_UNITS)
    ) u_arb (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (elig),
        .advance_i      (accept),
        .grant_onehot_o (grant_oh),
        .grant_idx_o    (grant_idx)
    );

    // Combinational request side: grant and SRAM address in the same cycle.
    always_comb begin
        bus_io.req_ready = grant_oh;
        mem_en           = accept;
        mem_addr         = accept ? bus_io.req_addr[grant_idx] : '0;
    end

    // Next state of the read pipeline and the per-unit response demux.
    always_comb begin
        s1_valid_d   = accept;
        s1_id_d      = accept ? grant_idx : s1_id_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        if (s1_valid_q) begin
            resp_valid_d           = N_UNITS'(onehot(32'(s1_id_q), N_UNITS));
            resp_data_d[s1_id_q]   = mem_rdata;
        end
    end

    // Pipeline and response registers; reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Registered response outputs and activity flag.
    always_comb begin
        bus_io.resp_valid = resp_valid_q;
        bus_io.resp_data  = resp_data_q;
        busy              = accept | s1_valid_q | (|resp_valid_q);
    end

endmodule

// File: tb/tb_unit_read_server.sv
// Bench for unit_read_server: directed scenarios plus a randomized run, all
// checked against a behavioural model of grant order and response delivery.
module tb_unit_read_server;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    unit_read_server_if #(.N_UNITS(N), .ADDR_W(16), .DATA_W(8)) bus ();

    unit_read_server #(.N_UNITS(N), .ADDR_W(16), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_io    (bus),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // SRAM model: 1-cycle read latency, garbage when not enabled.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= memf(mem_addr);
        else        mem_rdata <= 8'($urandom);
    end

    // Behavioural model state.
    int             m_ptr = 0;
    bit             m_p1_valid = 0;
    int             m_p1_id = 0;
    logic [15:0]    m_p1_addr = '0;
    logic [N-1:0]   exp_resp_valid = '0;
    logic [N-1:0][7:0] exp_resp_data = '0;
    logic [N-1:0]   exp_ready, obs_ready;
    logic           exp_mem_en, obs_mem_en, exp_busy, obs_busy;
    logic [15:0]    exp_mem_addr, obs_mem_addr;
    int             last_g = -1;

    // One clock: sample combinational outputs, predict, step the model.
    task automatic cycle();
        logic [N-1:0] e;
        logic [15:0]  g_addr;
        int           g;
        #1;
        e = bus.req_valid & bus.active_units & {N{rst_n}};
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && e[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        exp_ready = '0;
        g_addr    = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            g_addr       = bus.req_addr[g];
        end
        exp_mem_en   = (g >= 0);
        exp_mem_addr = g_addr;
        exp_busy     = (e != 0) || m_p1_valid || (exp_resp_valid != 0);
        obs_ready    = bus.req_ready;
        obs_mem_en   = mem_en;
        obs_mem_addr = mem_addr;
        obs_busy     = busy;
        last_g       = g;
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; m_p1_valid = 0; m_p1_id = 0;
            exp_resp_valid = '0; exp_resp_data = '0;
        end else begin
            exp_resp_valid = '0;
            if (m_p1_valid) begin
                exp_resp_valid[m_p1_id] = 1'b1;
                exp_resp_data[m_p1_id]  = memf(m_p1_addr);
            end
            if (g >= 0) begin
                m_p1_valid = 1; m_p1_id = g; m_p1_addr = g_addr; m_ptr = (g + 1) % N;
            end else begin
                m_p1_valid = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.active_units = '1;
        bus.req_valid    = '1;
        for (int u = 0; u < N; u++) bus.req_addr[u] = 16'($urandom);
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if (obs_ready !== 4'b0000) begin
                n_fail++; $display("FAIL reset_ready: got %b want 0000", obs_ready);
            end
            n_checks++;
            if (obs_mem_en !== 1'b0) begin
                n_fail++; $display("FAIL reset_mem_en: got %b want 0", obs_mem_en);
            end
            n_checks++;
            if (bus.resp_valid !== 4'b0000) begin
                n_fail++; $display("FAIL reset_resp_valid: got %b want 0000", bus.resp_valid);
            end
            n_checks++;
            if (bus.resp_data !== 32'h0) begin
                n_fail++; $display("FAIL reset_resp_data: got %h want 0", bus.resp_data);
            end
        end
        bus.req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_unit();
        logic [N-1:0]      rv [6];
        logic [N-1:0][7:0] rd [6];
        bus.active_units = '1;
        for (int i = 0; i < 6; i++) begin
            bus.req_valid = (i < 3) ? 4'b0010 : 4'b0000;
            bus.req_addr[1] = 16'(100 + i);
            cycle();
            rv[i] = bus.resp_valid;
            rd[i] = bus.resp_data;
            if (i < 3) begin
                n_checks++;
                if (obs_ready !== 4'b0010) begin
                    n_fail++; $display("FAIL single_ready[%0d]: got %b want 0010", i, obs_ready);
                end
                n_checks++;
                if (obs_mem_addr !== 16'(100 + i)) begin
                    n_fail++;
                    $display("FAIL single_mem_addr[%0d]: got %0d want %0d", i, obs_mem_addr, 100 + i);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (rv[i] !== ((i >= 1 && i <= 3) ? 4'b0010 : 4'b0000)) begin
                n_fail++; $display("FAIL single_resp_valid[%0d]: got %b", i, rv[i]);
            end
            if (i >= 1 && i <= 3) begin
                n_checks++;
                if (rd[i][1] !== 8'(99 + i)) begin
                    n_fail++;
                    $display("FAIL single_resp_data[%0d]: got %0d want %0d", i, rd[i][1], 99 + i);
                end
            end
        end
    endtask

    task automatic test_fair_mask();
        int order [3] = '{0, 2, 3};
        do_reset();
        bus.active_units = 4'b1101;
        bus.req_valid    = 4'b1111;
        for (int u = 0; u < N; u++) bus.req_addr[u] = 16'(100 + 3 * u);
        for (int i = 0; i < 11; i++) begin
            if (i == 9) bus.req_valid = '0;
            cycle();
            if (i < 9) begin
                n_checks++;
                if (obs_ready !== (4'b0001 << order[i % 3])) begin
                    n_fail++;
                    $display("FAIL mask_grant[%0d]: got %b want unit %0d", i, obs_ready, order[i % 3]);
                end
            end
            n_checks++;
            if (bus.resp_valid !== exp_resp_valid) begin
                n_fail++;
                $display("FAIL mask_resp_valid[%0d]: got %b want %b", i, bus.resp_valid, exp_resp_valid);
            end
            n_checks++;
            if (bus.resp_data !== exp_resp_data) begin
                n_fail++;
                $display("FAIL mask_resp_data[%0d]: got %h want %h", i, bus.resp_data, exp_resp_data);
            end
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] want [3] = '{4'b1000, 4'b0001, 4'b1000};
        logic [N-1:0] vld  [5] = '{4'b1000, 4'b1001, 4'b1000, 4'b0000, 4'b0000};
        bus.active_units = '1;
        for (int u = 0; u < N; u++) bus.req_addr[u] = 16'($urandom);
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = vld[i];
            cycle();
            if (i < 3) begin
                n_checks++;
                if (obs_ready !== want[i]) begin
                    n_fail++; $display("FAIL wrap_grant[%0d]: got %b want %b", i, obs_ready, want[i]);
                end
            end
            n_checks++;
            if (bus.resp_valid !== exp_resp_valid || bus.resp_data !== exp_resp_data) begin
                n_fail++;
                $display("FAIL wrap_resp[%0d]: got %b/%h want %b/%h", i, bus.resp_valid,
                         bus.resp_data, exp_resp_valid, exp_resp_data);
            end
        end
    endtask

    task automatic test_reset_midflight();
        bus.active_units = '1;
        for (int u = 0; u < N; u++) bus.req_addr[u] = 16'($urandom);
        bus.req_valid = 4'b0100;
        cycle();
        rst_n = 1'b0;
        bus.req_valid = 4'b1010;
        cycle();
        n_checks++;
        if (obs_ready !== 4'b0000 || obs_mem_en !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ready: got %b/%b want 0000/0", obs_ready, obs_mem_en);
        end
        n_checks++;
        if (bus.resp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_resp0: got %b want 0000", bus.resp_valid);
        end
        rst_n = 1'b1;
        cycle();
        n_checks++;
        if (obs_ready !== 4'b0010) begin
            n_fail++; $display("FAIL midrst_first_grant: got %b want 0010", obs_ready);
        end
        n_checks++;
        if (bus.resp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_resp1: got %b want 0000", bus.resp_valid);
        end
        bus.req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (i == 1) bus.req_valid = '0;
            n_checks++;
            if (bus.resp_valid !== exp_resp_valid || bus.resp_data !== exp_resp_data) begin
                n_fail++;
                $display("FAIL midrst_resp[%0d]: got %b/%h want %b/%h", i, bus.resp_valid,
                         bus.resp_data, exp_resp_valid, exp_resp_data);
            end
        end
    endtask

    task automatic test_mask_inflight();
        logic [15:0] a;
        do_reset();
        a = 16'($urandom);
        bus.active_units = '1;
        bus.req_valid    = 4'b0100;
        bus.req_addr[2]  = a;
        cycle();
        n_checks++;
        if (obs_ready !== 4'b0100) begin
            n_fail++; $display("FAIL inflight_accept: got %b want 0100", obs_ready);
        end
        bus.active_units = 4'b1011;
        bus.req_valid    = 4'b0101;
        bus.req_addr[2]  = 16'($urandom);
        cycle();
        n_checks++;
        if (bus.resp_valid !== 4'b0100) begin
            n_fail++; $display("FAIL inflight_resp_valid: got %b want 0100", bus.resp_valid);
        end
        n_checks++;
        if (bus.resp_data[2] !== memf(a)) begin
            n_fail++;
            $display("FAIL inflight_resp_data: got %h want %h", bus.resp_data[2], memf(a));
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.req_valid = '0;
            cycle();
            n_checks++;
            if (obs_ready[2] !== 1'b0) begin
                n_fail++; $display("FAIL inflight_no_grant[%0d]: got %b want 0", i, obs_ready[2]);
            end
            n_checks++;
            if (bus.resp_valid !== exp_resp_valid || bus.resp_data !== exp_resp_data) begin
                n_fail++;
                $display("FAIL inflight_resp[%0d]: got %b/%h want %b/%h", i, bus.resp_valid,
                         bus.resp_data, exp_resp_valid, exp_resp_data);
            end
        end
    endtask

    task automatic test_random();
        bus.active_units = '1;
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 9) == 0) bus.active_units = 4'($urandom);
            for (int u = 0; u < N; u++) begin
                // A request still waiting for its grant holds valid and addr.
                if (!(bus.req_valid[u] && last_g != u)) begin
                    bus.req_valid[u] = ($urandom_range(0, 2) != 0);
                    bus.req_addr[u]  = 16'($urandom);
                end
            end
            cycle();
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, obs_ready, exp_ready);
            end
            n_checks++;
            if (obs_mem_en !== exp_mem_en || obs_mem_addr !== exp_mem_addr) begin
                n_fail++;
                $display("FAIL rand_mem[%0d]: got %b/%h want %b/%h", i, obs_mem_en, obs_mem_addr,
                         exp_mem_en, exp_mem_addr);
            end
            n_checks++;
            if (obs_busy !== exp_busy) begin
                n_fail++; $display("FAIL rand_busy[%0d]: got %b want %b", i, obs_busy, exp_busy);
            end
            n_checks++;
            if (bus.resp_valid !== exp_resp_valid) begin
                n_fail++;
                $display("FAIL rand_resp_valid[%0d]: got %b want %b", i, bus.resp_valid, exp_resp_valid);
            end
            n_checks++;
            if (bus.resp_data !== exp_resp_data) begin
                n_fail++;
                $display("FAIL rand_resp_data[%0d]: got %h want %h", i, bus.resp_data, exp_resp_data);
            end
        end
        rst_n = 1'b1;
        bus.req_valid = '0;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.active_units = '0;
        bus.req_valid    = '0;
        bus.req_addr     = '0;
        test_reset();
        test_single_unit();
        test_fair_mask();
        test_wrap();
        test_reset_midflight();
        test_mask_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unit_read_server.md
# unit_read_server

Read-side responder for the per-unit address streams produced by the pointer array. It accepts up to N_UNITS concurrent read requests, arbitrates them round-robin onto one single-port synchronous SRAM with 1-cycle read latency, and returns each word to the unit that requested it. It sits between the pointer array and the weight/bias SRAM, and feeds the MAC units.

## Interface
- N_UNITS, 4: number of requesting units (2..16)
- ADDR_W, 16: request and SRAM address width
- DATA_W, 8: SRAM word width
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  synchronous, active-low reset
- active_units  in  N_UNITS  per-unit enable mask; a masked unit is never granted
- req_valid  in  N_UNITS  per-unit read request
- req_addr  in  N_UNITS x ADDR_W  per-unit address, held stable while req_valid=1 and not yet accepted
- req_ready  out  N_UNITS  one-hot grant; the request is accepted on a clock edge where req_valid[i] & req_ready[i]
- resp_valid  out  N_UNITS  one-cycle pulse; resp_data[i] is valid for unit i
- resp_data  out  N_UNITS x DATA_W  per-unit returned word; holds its value until that unit's next response
- mem_en  out  1  SRAM read enable
- mem_addr  out  ADDR_W  SRAM address
- mem_rdata  in  DATA_W  SRAM data, valid in the cycle after the mem_en edge
- busy  out  1  high while any request is pending or a read is in flight

## Operation
- Eligible set E = req_valid & active_units & {N_UNITS{rst_n}}.
- Arbitration is round-robin with pointer rr_ptr. The grant g is the first eligible index found scanning from rr_ptr upward and wrapping modulo N_UNITS.
- Arbitration is combinational in the same cycle:
  - req_ready = onehot(g) when E≠0, else 0.
  - mem_en = |E.
  - mem_addr = req_addr[g] when mem_en=1, else 0.
- On an accept edge:
  - rr_ptr ← (g+1) mod N_UNITS.
  - Pipeline register captures s1_valid=1 and s1_id=g.
- With no accept: rr_ptr holds and s1_valid ← 0.
- Response stage, when s1_valid=1: at the next edge, resp_data[s1_id] ← mem_rdata, resp_valid ← onehot(s1_id). Otherwise resp_valid ← 0.
- No backpressure on responses. Units must sink resp_valid when it is asserted.
- Throughput is one accept per cycle sustained.
- busy = |E | s1_valid | (|resp_valid).
- Clearing an active_units bit while a unit's read is in flight does not cancel that read; the response is still delivered.
- Address width rule: mem_addr passes ADDR_W bits unchanged. The block does no address arithmetic.

## Timing
- Accept at edge E0 → SRAM samples at E0 → mem_rdata valid during cycle E0..E1 → resp_valid/resp_data registered at E1 and visible during the cycle after E1.
- Latency is 2 edges from accept to the response being visible.
- Reset values (rst_n=0 at an edge): rr_ptr=0, s1_valid=0, s1_id=0, resp_valid=0, all resp_data=0.
- While rst_n=0, req_ready=0 and mem_en=0 combinationally.
- Reset mid-operation: in-flight reads are discarded with no resp_valid. The first post-reset grant starts scanning from unit 0.
- Simultaneous requests: exactly one grant per cycle. Losers must hold req_valid and req_addr.
- Wrap-around: a grant to N_UNITS-1 sets rr_ptr to 0.
- Only one unit requesting: that unit is granted every cycle, back-to-back, with no bubbles.

## Structure
- The shared package ttpu_pkg holds the default ADDR_W/DATA_W localparams and a function onehot(idx, n).
- Sub-module rr_arbiter #(N) contains the round-robin pointer and grant logic.
  - Inputs: clk, rst_n, req, advance.
  - Outputs: grant_onehot, grant_idx.
  - It is instanced once.
- The top level holds the pipeline registers and the response demux.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with all req_valid=1 → req_ready=0, mem_en=0, resp_valid=0, resp_data all 0.
- Single unit:
  - Stimulus: SRAM model mem[a]=a[7:0]. Unit 1 requests addr 100, 101, 102 back-to-back.
  - Required response: resp_valid[1] on 3 consecutive cycles, starting 2 edges after the first accept, with data 100, 101, 102. Other units see no pulses.
- Fairness with a mask:
  - Stimulus: active_units=4'b1101; all four units hold req_valid=1 with addresses 100, 103, 106, 109.
  - Required response: grant order 0, 2, 3, 0, 2, 3… Unit 1 is never granted. Each response carries the data for its own unit's address.
- Wrap and pointer:
  - Stimulus: only unit 3 requests once. Then units 0 and 3 request together.
  - Required response: unit 0 is granted first, then unit 3.
- Reset mid-flight: assert rst_n=0 on the edge right after an accept → no resp_valid for that read. After release, the first grant comes from the lowest eligible index.
- Mask change in flight: clear active_units[2] the cycle after unit 2 is accepted → unit 2 still receives resp_valid[2] with the correct data. Unit 2 gets no further grants.
